// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with shadow/display double-buffering.
// Define SEG7_LZB_EN to enable leading-zero blanking on the display register.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 16,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iLOAD,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oDIG_SEL,
  output logic                    oFRAME,
  output logic                    oPENDING
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] POL_MASK =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    tick;
  logic                    boundary;
  logic [3:0]              cur_nib;
  logic                    cur_dp;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;  4'h1: pat = 8'hF9;  4'h2: pat = 8'hA4;  4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;  4'h5: pat = 8'h92;  4'h6: pat = 8'h82;  4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;  4'h9: pat = 8'h98;  4'hA: pat = 8'h88;  4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;  4'hD: pat = 8'hA1;  4'hE: pat = 8'h86;  default: pat = 8'h8E;
    endcase
    return pat[6:0];
  endfunction

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;

  // A digit is blanked when it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run     = zero_run && (disp_data_d[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
  end
`endif

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pending_d     = pending_q;

    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == IDX_MAX);

    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end

    if (iLOAD) begin
      shadow_data_d = iDATA;
      shadow_dp_d   = iDP;
      pending_d     = 1'b1;
    end

    // The display buffer only changes on the wrap, so a frame is never torn.
    if (boundary) begin
      pending_d = 1'b0;
      if (iLOAD) begin
        disp_data_d = iDATA;
        disp_dp_d   = iDP;
      end else if (pending_q) begin
        disp_data_d = shadow_data_q;
        disp_dp_d   = shadow_dp_q;
      end
    end

    // Outputs are built from next-state values so they line up with the slot counter.
    cur_nib = disp_data_d[{idx_d, 2'b00} +: 4];
    cur_dp  = disp_dp_d[idx_d];
    seg_d   = {~cur_dp, hex7(cur_nib)};
`ifdef SEG7_LZB_EN
    if (lead_zero[idx_d]) begin
      seg_d = cur_dp ? 8'h7F : 8'hFF;
    end
`endif

    if (cnt_d < CNT_BLANK) begin
      dig_d = POL_MASK;
    end else begin
      dig_d = (NUM_DIGITS'(1) << idx_d) ^ POL_MASK;
    end

    frame_d = boundary;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      seg_q         <= 8'hFF;
      dig_q         <= POL_MASK;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      frame_q       <= frame_d;
    end
  end

  assign oSEG     = seg_q;
  assign oDIG_SEL = dig_q;
  assign oFRAME   = frame_q;
  assign oPENDING = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle, active-low selects).
module tb_seg7_scan_driver;

  logic        iCLK;
  logic        iRST_N;
  logic [15:0] iDATA;
  logic [3:0]  iDP;
  logic        iLOAD;
  logic [7:0]  oSEG;
  logic [3:0]  oDIG_SEL;
  logic        oFRAME;
  logic        oPENDING;

  int checks = 0;
  int passed = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4),
    .CLK_DIV(4),
    .BLANK_CYC(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iDATA(iDATA),
    .iDP(iDP),
    .iLOAD(iLOAD),
    .oSEG(oSEG),
    .oDIG_SEL(oDIG_SEL),
    .oFRAME(oFRAME),
    .oPENDING(oPENDING)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge carrying oFRAME, within a bounded window.
  task automatic wait_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge iCLK);
      if (oFRAME) found = 1'b1;
    end
    check({tag, "_frame_seen"}, 32'(found), 32'd1);
  endtask

  // Called on a frame's first cycle; checks every slot, returns at the next frame's first cycle.
  task automatic scan_check(input string tag, input logic [31:0] exp_segs);
    logic [7:0] e;
    check({tag, "_blank0"}, 32'(oDIG_SEL), 32'hF);
    check({tag, "_seg0_c0"}, 32'(oSEG), 32'(exp_segs[7:0]));
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLK);
      e = exp_segs[8*k +: 8];
      check($sformatf("%s_seg%0d", tag, k), 32'(oSEG), 32'(e));
      check($sformatf("%s_sel%0d", tag, k), 32'(oDIG_SEL), 32'(4'hF & ~(4'b0001 << k)));
      repeat (3) @(negedge iCLK);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    iDATA = d;
    iDP   = dp;
    iLOAD = 1'b1;
    @(negedge iCLK);
    iLOAD = 1'b0;
  endtask

  initial begin
    int n;
    iRST_N = 1'b0;
    iDATA  = '0;
    iDP    = '0;
    iLOAD  = 1'b0;

    repeat (3) @(negedge iCLK);
    check("rst_seg", 32'(oSEG), 32'hFF);
    check("rst_sel", 32'(oDIG_SEL), 32'hF);
    check("rst_frame", 32'(oFRAME), 32'd0);
    check("rst_pending", 32'(oPENDING), 32'd0);

    iRST_N = 1'b1;
    @(negedge iCLK);
    check("first_seg", 32'(oSEG), 32'hC0);
    check("first_sel", 32'(oDIG_SEL), 32'hE);
    check("first_frame", 32'(oFRAME), 32'd0);

    wait_frame("init");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      n++;
      if (oFRAME) break;
    end
    check("frame_period", 32'(n), 32'd16);

    // Mid-frame load: held in shadow until the wrap.
    repeat (5) @(negedge iCLK);
    load(16'h1A3F, 4'b0010);
    check("mid_pending", 32'(oPENDING), 32'd1);
    check("mid_seg_unchanged", 32'(oSEG), 32'hC0);
    wait_frame("mid");
    check("mid_pending_clr", 32'(oPENDING), 32'd0);
    scan_check("mid", {8'hF9, 8'h88, 8'h30, 8'h8E});

    // Two loads in one frame: last one wins, current frame unaffected.
    repeat (2) @(negedge iCLK);
    load(16'h1111, 4'b0000);
    repeat (3) @(negedge iCLK);
    load(16'h2222, 4'b0000);
    check("dbl_pending", 32'(oPENDING), 32'd1);
    repeat (6) @(negedge iCLK);
    check("dbl_old_seg3", 32'(oSEG), 32'hF9);
    check("dbl_old_sel3", 32'(oDIG_SEL), 32'h7);
    repeat (3) @(negedge iCLK);
    check("dbl_frame", 32'(oFRAME), 32'd1);
    scan_check("dbl", {8'hA4, 8'hA4, 8'hA4, 8'hA4});

    // Load on the wrap cycle goes straight to the display.
    repeat (15) @(negedge iCLK);
    load(16'h0008, 4'b0000);
    check("bnd_frame", 32'(oFRAME), 32'd1);
    check("bnd_pending", 32'(oPENDING), 32'd0);
    scan_check("bnd", {8'hC0, 8'hC0, 8'hC0, 8'h80});
    check("bnd_pending_after", 32'(oPENDING), 32'd0);

    // Leading zeros: blanked only when the feature is compiled in.
    repeat (3) @(negedge iCLK);
    load(16'h0050, 4'b0000);
    wait_frame("lzb");
`ifdef SEG7_LZB_EN
    scan_check("lzb", {8'hFF, 8'hFF, 8'h92, 8'hC0});
`else
    scan_check("lzb", {8'hC0, 8'hC0, 8'h92, 8'hC0});
`endif

    // Asynchronous reset mid-slot drops pending data and outputs at once.
    repeat (2) @(negedge iCLK);
    load(16'h1234, 4'b1111);
    check("ar_pending_set", 32'(oPENDING), 32'd1);
    repeat (2) @(negedge iCLK);
    check("ar_sel_active", 32'(oDIG_SEL), 32'hD);
    #2 iRST_N = 1'b0;
    #1;
    check("ar_seg", 32'(oSEG), 32'hFF);
    check("ar_sel", 32'(oDIG_SEL), 32'hF);
    check("ar_pending", 32'(oPENDING), 32'd0);
    check("ar_frame", 32'(oFRAME), 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    check("ar_restart_seg", 32'(oSEG), 32'hC0);
    check("ar_restart_sel", 32'(oDIG_SEL), 32'hE);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
